// File: rtl/apb_requester_if.sv
// APB requester bus bundle: CPU request/response channel plus the APB
// completer-facing signals. The requester uses the master modport; the
// CPU/completer side (or a testbench) uses the slave modport.
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 32
) ();
  // CPU request channel
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  // CPU response channel
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  // APB channel
  logic [ADDR_WIDTH-1:0] paddr;
  logic [31:0]           pdata;
  logic [31:0]           prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned,
    input  prdata, pready, perr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, pdata, psel, penable, pwrite, pstb
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned,
    output prdata, pready, perr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, pdata, psel, penable, pwrite, pstb
  );
endinterface

// File: rtl/apb_requester.sv
// apb_requester: turns single CPU load/store requests into APB transfers.
// FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; misaligned requests skip the
// bus and go straight to RESP with an error. Byte/half stores are lane
// replicated with strobes; loads are shifted and sign/zero extended.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles without pready (otherwise ACCESS waits forever).
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            pclk,
  input  logic            presetn,
  apb_requester_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [3:0]            r_pstb;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           w_load_data;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  // Size 11 is reserved and always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic write, input logic [1:0] size,
                                              input logic [1:0] off);
    if (!write) return 4'b0000;
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across all lanes so strobes pick the lane.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off,
                                              input logic uns, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign w_load_data = load_extend(r_size, r_paddr[1:0], r_unsigned, bus.prdata);

  // Request/APB sequencing FSM; every output is a register updated here.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_paddr     <= '0;
      r_pdata     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pstb      <= 4'b0000;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_paddr     <= bus.req_addr;
            r_pwrite    <= bus.req_write;
            r_pdata     <= store_data(bus.req_size, bus.req_wdata);
            r_size      <= bus.req_size;
            r_unsigned  <= bus.req_unsigned;
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state <= S_SETUP;
              r_psel  <= 1'b1;
              r_pstb  <= store_strobe(bus.req_write, bus.req_size, bus.req_addr[1:0]);
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        S_ACCESS: begin
          if (bus.pready) begin
            r_state     <= S_RESP;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pstb      <= 4'b0000;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus.perr;
            r_rsp_rdata <= (bus.perr || r_pwrite) ? '0 : w_load_data;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= S_RESP;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pstb      <= 4'b0000;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.paddr     = r_paddr;
  assign bus.pdata     = r_pdata;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.pstb      = r_pstb;

endmodule

// File: tb/tb_apb_requester.sv
// Testbench for apb_requester: directed scenarios plus randomized traffic,
// each request compared cycle by cycle against a behavioural model.
module tb_apb_requester;

  localparam int TMO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic pclk;
  logic presetn;
  int   n_checks;
  int   n_fail;

  apb_requester_if #(.ADDR_WIDTH(32)) bus ();

  apb_requester #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Load result from the arithmetic rules: shift, mask, then sign-adjust.
  function automatic logic [31:0] model_load(input logic [1:0] size, input int off,
                                             input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // One full request, driven from an idle negedge and checked every cycle
  // until the bus is idle again.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                     input logic [1:0] size, input logic uns, input int waits,
                     input logic [31:0] rd, input logic pe);
    int          off;
    int          lat;
    logic        mis;
    logic        abort;
    logic        e_err;
    logic [3:0]  e_stb;
    logic [31:0] e_pdata;
    logic [31:0] e_rdata;
    logic        hit;

    off   = int'(addr % 4);
    mis   = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
    abort = !mis && TMO_EN && waits >= TMO;
    lat   = mis ? 1 : (abort ? 2 + TMO : 3 + waits);
    if (!wr)               e_stb = 4'b0000;
    else if (size == 2'd0) e_stb = 4'(1 << off);
    else if (size == 2'd1) e_stb = 4'(3 << off);
    else                   e_stb = 4'b1111;
    if (size == 2'd0)      e_pdata = (wdata % 256) * 32'h0101_0101;
    else if (size == 2'd1) e_pdata = (wdata % 65536) * 32'h0001_0001;
    else                   e_pdata = wdata;
    e_err   = mis || abort || pe;
    e_rdata = (e_err || wr) ? 32'd0 : model_load(size, off, uns, rd);

    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_write    = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.pready       = 1'b0;
    bus.prdata       = $urandom;
    bus.perr         = 1'($urandom_range(0, 1));
    @(posedge pclk);
    @(negedge pclk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    for (int c = 1; c <= lat; c++) begin
      chk("psel", 32'(bus.psel), 32'(!mis && c < lat));
      chk("penable", 32'(bus.penable), 32'(!mis && c >= 2 && c < lat));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(c == lat));
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (!mis && c < lat) begin
        chk("paddr", bus.paddr, addr);
        chk("pwrite", 32'(bus.pwrite), 32'(wr));
        chk("pstb", 32'(bus.pstb), 32'(e_stb));
        if (wr) chk("pdata", bus.pdata, e_pdata);
      end
      if (c == lat) begin
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("pstb_resp", 32'(bus.pstb), 32'd0);
      end
      hit = !mis && !abort && (c == 2 + waits);
      bus.pready = hit;
      bus.prdata = hit ? rd : $urandom;
      bus.perr   = hit ? pe : 1'($urandom_range(0, 1));
      @(posedge pclk);
      @(negedge pclk);
    end

    chk("rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    chk("psel_after", 32'(bus.psel), 32'd0);
    chk("req_ready_after", 32'(bus.req_ready), 32'd1);
    bus.pready = 1'b0;
    bus.perr   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
    chk({tag, "_psel"},      32'(bus.psel),      32'd0);
    chk({tag, "_penable"},   32'(bus.penable),   32'd0);
    chk({tag, "_pwrite"},    32'(bus.pwrite),    32'd0);
    chk({tag, "_pstb"},      32'(bus.pstb),      32'd0);
    chk({tag, "_paddr"},     bus.paddr,          32'd0);
    chk({tag, "_pdata"},     bus.pdata,          32'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    presetn          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.prdata       = '0;
    bus.pready       = 1'b0;
    bus.perr         = 1'b0;

    repeat (3) @(negedge pclk);
    chk_all_zero("reset");
    presetn = 1'b1;
    chk("req_ready_release", 32'(bus.req_ready), 32'd0);
    @(negedge pclk);
    chk("req_ready_first_edge", 32'(bus.req_ready), 32'd1);

    // Directed scenarios
    txn(32'h8000_0000, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
    txn(32'h1000_0005, 32'h0000_00A5, 1'b1, 2'd0, 1'b0, 2, 32'h0, 1'b0);
    txn(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b0, 1, 32'h8001_1234, 1'b0);
    txn(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b1, 0, 32'h8001_1234, 1'b0);
    txn(32'h8000_0001, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'h1234_5678, 1'b0);
    txn(32'h0000_2000, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'h1234_5678, 1'b1);
    txn(32'h0000_2003, 32'h0, 1'b0, 2'd1, 1'b0, 0, 32'h1234_5678, 1'b0);
    txn(32'h0000_2000, 32'h0, 1'b0, 2'd3, 1'b0, 0, 32'h1234_5678, 1'b0);
    txn(32'h0000_2003, 32'h0, 1'b0, 2'd0, 1'b0, 3, 32'h80FF_FFFF, 1'b0);
    txn(32'h0000_2006, 32'hCAFE_1234, 1'b1, 2'd1, 1'b0, 0, 32'h0, 1'b0);
    txn(32'h0000_2008, 32'hCAFE_1234, 1'b1, 2'd2, 1'b0, 1, 32'h0, 1'b1);
`ifdef APB_TIMEOUT_EN
    txn(32'h0000_3000, 32'h0, 1'b0, 2'd2, 1'b0, 10, 32'h5555_AAAA, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      txn($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom,
          ($urandom_range(0, 7) == 0));
    end

    // Reset while the transfer sits in ACCESS
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_4000;
    bus.req_wdata = 32'h1357_9BDF;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    @(posedge pclk);
    @(negedge pclk);
    bus.req_valid = 1'b0;
    chk("abort_setup_psel", 32'(bus.psel), 32'd1);
    @(posedge pclk);
    @(negedge pclk);
    chk("abort_access_penable", 32'(bus.penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("abort_psel", 32'(bus.psel), 32'd0);
    end
    presetn = 1'b1;
    chk("abort_ready_release", 32'(bus.req_ready), 32'd0);
    @(negedge pclk);
    chk("abort_ready_first_edge", 32'(bus.req_ready), 32'd1);
    txn(32'h0000_4004, 32'h0, 1'b0, 2'd2, 1'b0, 1, 32'h0BAD_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
